// File: rtl/ecc_point_seq.sv
// rtl/ecc_point_seq.sv - elliptic-curve point addition sequencer driving an external GF(p) arithmetic unit
//
// Computes R = P + Q in affine coordinates by running a short microprogram
// of add/sub/mul/div operations on an external GFAU, one operation at a time.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_start                 one-cycle request, honoured only while idle
//   i_x1, i_y1, i_x2, i_y2  operand points P and Q
//   i_a                     curve coefficient a
//   i_prime                 field modulus (consumed by the GFAU, not here)
//   o_busy, o_done, o_err   status: busy level, done pulse, timeout pulse
//   o_inf, o_x3, o_y3       result, held until the next completion
//   o_gf_op, o_gf_in_0/1    GFAU opcode and operands, held while waiting
//   o_gf_start              GFAU start pulse
//   i_gf_result, i_gf_done  GFAU result and completion pulse
module ecc_point_seq #(
    parameter int SIZE    = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [SIZE-1:0] i_x1,
    input  logic [SIZE-1:0] i_y1,
    input  logic [SIZE-1:0] i_x2,
    input  logic [SIZE-1:0] i_y2,
    input  logic [SIZE-1:0] i_a,
    input  logic [SIZE-1:0] i_prime,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err,
    output logic            o_inf,
    output logic [SIZE-1:0] o_x3,
    output logic [SIZE-1:0] o_y3,
    output logic [1:0]      o_gf_op,
    output logic [SIZE-1:0] o_gf_in_0,
    output logic [SIZE-1:0] o_gf_in_1,
    output logic            o_gf_start,
    input  logic [SIZE-1:0] i_gf_result,
    input  logic            i_gf_done
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_FINISH} state_t;

    localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;
    localparam logic [3:0] R_X1 = 4'd0, R_Y1 = 4'd1, R_X2 = 4'd2, R_Y2 = 4'd3, R_A  = 4'd4,
                           R_L  = 4'd5, R_T0 = 4'd6, R_T1 = 4'd7, R_X3 = 4'd8, R_Y3 = 4'd9;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] s0;
        logic [3:0] s1;
        logic [3:0] dst;
        logic       last;
    } uop_t;

    function automatic uop_t ucode(input logic dbl, input logic [3:0] step);
        uop_t u;
        u = '0;
        if (!dbl) begin
            case (step)
                4'd0: u = '{OP_SUB, R_Y2, R_Y1, R_T0, 1'b0};
                4'd1: u = '{OP_SUB, R_X2, R_X1, R_T1, 1'b0};
                4'd2: u = '{OP_DIV, R_T0, R_T1, R_L,  1'b0};
                4'd3: u = '{OP_MUL, R_L,  R_L,  R_T0, 1'b0};
                4'd4: u = '{OP_SUB, R_T0, R_X1, R_T0, 1'b0};
                4'd5: u = '{OP_SUB, R_T0, R_X2, R_X3, 1'b0};
                4'd6: u = '{OP_SUB, R_X1, R_X3, R_T1, 1'b0};
                4'd7: u = '{OP_MUL, R_L,  R_T1, R_T0, 1'b0};
                4'd8: u = '{OP_SUB, R_T0, R_Y1, R_Y3, 1'b1};
                default: u = '0;
            endcase
        end else begin
            case (step)
                4'd0:  u = '{OP_MUL, R_X1, R_X1, R_T0, 1'b0};
                4'd1:  u = '{OP_ADD, R_T0, R_T0, R_T1, 1'b0};
                4'd2:  u = '{OP_ADD, R_T1, R_T0, R_T0, 1'b0};
                4'd3:  u = '{OP_ADD, R_T0, R_A,  R_T0, 1'b0};
                4'd4:  u = '{OP_ADD, R_Y1, R_Y1, R_T1, 1'b0};
                4'd5:  u = '{OP_DIV, R_T0, R_T1, R_L,  1'b0};
                4'd6:  u = '{OP_MUL, R_L,  R_L,  R_T0, 1'b0};
                4'd7:  u = '{OP_SUB, R_T0, R_X1, R_T0, 1'b0};
                4'd8:  u = '{OP_SUB, R_T0, R_X1, R_X3, 1'b0};
                4'd9:  u = '{OP_SUB, R_X1, R_X3, R_T1, 1'b0};
                4'd10: u = '{OP_MUL, R_L,  R_T1, R_T0, 1'b0};
                4'd11: u = '{OP_SUB, R_T0, R_Y1, R_Y3, 1'b1};
                default: u = '0;
            endcase
        end
        return u;
    endfunction

    state_t          state_q, state_d;
    logic [3:0]      step_q, step_d;
    logic            dbl_q, dbl_d;
    logic            inf_q, inf_d;
    logic [CW-1:0]   cnt_q;
    logic [SIZE-1:0] rf_q [0:9];

    logic            busy_q, done_q, err_q, inf_out_q, gf_start_q;
    logic [SIZE-1:0] x3_q, y3_q, gf_in_0_q, gf_in_1_q;
    logic [1:0]      gf_op_q;

    logic            load_issue, wr_en, timeout;
    uop_t            uop_cur, uop_iss;
    logic [SIZE-1:0] op0_d, op1_d, x3_fin, y3_fin;
    logic            x_eq, y_eq, y1_zero;

    // The modulus is applied inside the GFAU; the sequencer never needs it.
    logic            unused_prime;
    assign unused_prime = ^i_prime;

    assign uop_cur = ucode(dbl_q, step_q);
    assign x_eq    = (rf_q[R_X1] == rf_q[R_X2]);
    assign y_eq    = (rf_q[R_Y1] == rf_q[R_Y2]);
    assign y1_zero = (rf_q[R_Y1] == '0);

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        dbl_d      = dbl_q;
        inf_d      = inf_q;
        load_issue = 1'b0;
        wr_en      = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            S_IDLE: if (i_start) state_d = S_CHECK;
            S_CHECK: begin
                step_d = '0;
                if (x_eq && (!y_eq || y1_zero)) begin
                    inf_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    inf_d      = 1'b0;
                    dbl_d      = x_eq;
                    load_issue = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (i_gf_done) begin
                    wr_en = 1'b1;
                    if (uop_cur.last) begin
                        state_d = S_FINISH;
                    end else begin
                        step_d     = step_q + 4'd1;
                        load_issue = 1'b1;
                        state_d    = S_ISSUE;
                    end
                end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Operands for the next step are fetched on the same edge that
        // stores the previous result, so forward that result directly.
        uop_iss = ucode(dbl_d, step_d);
        op0_d   = (wr_en && uop_iss.s0 == uop_cur.dst) ? i_gf_result : rf_q[uop_iss.s0];
        op1_d   = (wr_en && uop_iss.s1 == uop_cur.dst) ? i_gf_result : rf_q[uop_iss.s1];
        x3_fin  = (wr_en && uop_cur.dst == R_X3) ? i_gf_result : rf_q[R_X3];
        y3_fin  = (wr_en && uop_cur.dst == R_Y3) ? i_gf_result : rf_q[R_Y3];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            dbl_q      <= 1'b0;
            inf_q      <= 1'b0;
            cnt_q      <= '0;
            for (int i = 0; i < 10; i++) rf_q[i] <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            inf_out_q  <= 1'b0;
            x3_q       <= '0;
            y3_q       <= '0;
            gf_op_q    <= '0;
            gf_in_0_q  <= '0;
            gf_in_1_q  <= '0;
            gf_start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            dbl_q   <= dbl_d;
            inf_q   <= inf_d;

            if (state_q == S_IDLE && i_start) begin
                rf_q[R_X1] <= i_x1;
                rf_q[R_Y1] <= i_y1;
                rf_q[R_X2] <= i_x2;
                rf_q[R_Y2] <= i_y2;
                rf_q[R_A]  <= i_a;
            end
            if (wr_en) rf_q[uop_cur.dst] <= i_gf_result;

            // cnt_q counts cycles since the start pulse.
            if (load_issue) begin
                gf_op_q   <= uop_iss.op;
                gf_in_0_q <= op0_d;
                gf_in_1_q <= op1_d;
                cnt_q     <= CW'(1);
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q + CW'(1);
            end
            gf_start_q <= load_issue;

            busy_q <= (state_d == S_CHECK) || (state_d == S_ISSUE) || (state_d == S_WAIT);
            done_q <= (state_d == S_FINISH);
            err_q  <= timeout;
            if (state_d == S_FINISH) begin
                inf_out_q <= inf_d;
                x3_q      <= inf_d ? '0 : x3_fin;
                y3_q      <= inf_d ? '0 : y3_fin;
            end
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_inf      = inf_out_q;
    assign o_x3       = x3_q;
    assign o_y3       = y3_q;
    assign o_gf_op    = gf_op_q;
    assign o_gf_in_0  = gf_in_0_q;
    assign o_gf_in_1  = gf_in_1_q;
    assign o_gf_start = gf_start_q;
endmodule

// File: tb/tb_ecc_point_seq.sv
// tb/tb_ecc_point_seq.sv - bench for ecc_point_seq with a mod-17 GFAU model
module tb_ecc_point_seq;
    localparam int TO = 1023;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0, a = '0, prime = 32'd17;
    logic        busy, done, err, inf, gf_start;
    logic [31:0] x3, y3, gf_in_0, gf_in_1;
    logic [1:0]  gf_op;
    logic [31:0] gf_result = '0;
    logic        gf_done = 1'b0;
    bit          gf_en = 1'b1;

    int checks = 0;
    int errors = 0;
    int nstarts = 0;
    bit prev_start = 1'b0;
    bit back_to_back = 1'b0;

    ecc_point_seq #(.SIZE(32), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_x1(x1), .i_y1(y1), .i_x2(x2), .i_y2(y2), .i_a(a), .i_prime(prime),
        .o_busy(busy), .o_done(done), .o_err(err), .o_inf(inf),
        .o_x3(x3), .o_y3(y3),
        .o_gf_op(gf_op), .o_gf_in_0(gf_in_0), .o_gf_in_1(gf_in_1), .o_gf_start(gf_start),
        .i_gf_result(gf_result), .i_gf_done(gf_done)
    );

    always #5 clk = ~clk;

    function automatic int gf_calc(input int op, input int u, input int v, input int p);
        int inv;
        inv = 0;
        case (op)
            0: return (u + v) % p;
            1: return (u - v + p) % p;
            2: return (u * v) % p;
            default: begin
                for (int k = 1; k < p; k++) if ((v * k) % p == 1) inv = k;
                return (u * inv) % p;
            end
        endcase
    endfunction

    // GFAU model: add/sub done one cycle after start, mul/div three cycles.
    int m_cnt = 0;
    int m_res = 0;
    bit m_busy = 1'b0;
    always @(negedge clk) begin
        gf_done = 1'b0;
        if (m_busy) begin
            if (m_cnt == 0) begin
                gf_done   = 1'b1;
                gf_result = m_res;
                m_busy    = 1'b0;
            end else begin
                m_cnt--;
            end
        end
        if (gf_start && gf_en) begin
            m_busy = 1'b1;
            m_cnt  = (gf_op >= 2'd2) ? 2 : 0;
            m_res  = gf_calc(int'(gf_op), int'(gf_in_0), int'(gf_in_1), int'(prime));
        end
    end

    always @(negedge clk) begin
        if (gf_start) begin
            nstarts++;
            if (prev_start) back_to_back = 1'b1;
        end
        prev_start = gf_start;
    end

    typedef struct {
        int x1, y1, x2, y2, a;
        int inf, x3, y3, starts, lat;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm, input bit extra);
        int n, s0;
        bit got;
        @(negedge clk);
        x1 = v.x1; y1 = v.y1; x2 = v.x2; y2 = v.y2; a = v.a;
        start = 1'b1;
        s0 = nstarts;
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (extra && n == 5) begin
                start = 1'b1;
                x1 = 9; y1 = 9;
            end
            if (done) got = 1'b1;
        end
        chk({nm, " done"}, got, 1);
        chk({nm, " latency"}, n, v.lat);
        chk({nm, " x3"}, x3, v.x3);
        chk({nm, " y3"}, y3, v.y3);
        chk({nm, " inf"}, inf, v.inf);
        chk({nm, " starts"}, nstarts - s0, v.starts);
        chk({nm, " busy after done"}, busy, 0);
    endtask

    vec_t vecs[8];

    initial begin
        int n, k;
        bit saw_done;
        //          x1 y1 x2 y2  a  inf x3 y3 starts lat
        vecs[0] = '{5,  1, 5,  1, 2, 0,  6,  3, 12, 34};
        vecs[1] = '{5,  1, 6,  3, 2, 0, 10,  6,  9, 26};
        vecs[2] = '{5,  1, 5, 16, 2, 1,  0,  0,  0,  2};
        vecs[3] = '{3,  0, 3,  0, 2, 1,  0,  0,  0,  2};
        vecs[4] = '{6,  3, 10, 6, 2, 0,  9, 16,  9, 26};
        vecs[5] = '{6,  3, 6,  3, 2, 0,  3,  1, 12, 34};
        vecs[6] = '{4,  2, 4,  7, 2, 1,  0,  0,  0,  2};
        vecs[7] = '{0,  5, 1,  1, 2, 0, 15,  4,  9, 26};

        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset x3", x3, 0);
        chk("reset gf_start", gf_start, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);

        // A second request while busy must not disturb the running one.
        run_vec(vecs[1], "restart_ignored", 1'b1);
        run_vec(vecs[7], "before_timeout", 1'b0);

        // GFAU never answers: error pulse TIMEOUT cycles after the start pulse.
        gf_en = 1'b0;
        @(negedge clk);
        x1 = 5; y1 = 1; x2 = 6; y2 = 3; a = 2;
        start = 1'b1;
        n = 0;
        while (!gf_start && n < 10) begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        chk("timeout start seen", gf_start, 1);
        n = 0;
        saw_done = 1'b0;
        while (!err && n < TO + 10) begin
            @(negedge clk);
            n++;
            if (done) saw_done = 1'b1;
        end
        chk("timeout err seen", err, 1);
        chk("timeout cycles", n, TO);
        chk("timeout busy", busy, 0);
        chk("timeout no done", saw_done, 0);
        chk("timeout x3 held", x3, 15);
        chk("timeout y3 held", y3, 4);
        gf_en = 1'b1;
        @(negedge clk);
        chk("err single pulse", err, 0);
        run_vec(vecs[1], "after_timeout", 1'b0);

        // Reset while waiting on step 4 of a doubling.
        @(negedge clk);
        x1 = 5; y1 = 1; x2 = 5; y2 = 1; a = 2;
        start = 1'b1;
        k = 0;
        n = 0;
        while (k < 5 && n < 100) begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (gf_start) k++;
        end
        chk("reset test reached step4", k, 5);
        @(negedge clk);
        chk("reset test in wait", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset x3", x3, 0);
        chk("midreset y3", y3, 0);
        chk("midreset inf", inf, 0);
        chk("midreset gf_op", gf_op, 0);
        chk("midreset gf_in_0", gf_in_0, 0);
        chk("midreset gf_in_1", gf_in_1, 0);
        chk("midreset gf_start", gf_start, 0);
        chk("midreset done", done, 0);
        chk("midreset err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || err) saw_done = 1'b1;
        end
        chk("no pulse after abort", saw_done, 0);
        run_vec(vecs[0], "after_reset", 1'b0);

        chk("no back-to-back start", back_to_back, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
